serial_transmitter: RTL and testbench

- Upstream companion of the serial receiver. Takes parallel bytes over a valid/ready write port, buffers them in a small FIFO, and serialises them onto a single line at one bit per Clock.
- Frame format: start bit 0, 8 data bits MSB first, then STOP_BITS stop bits of 1. The line idles high.
- Out connects directly to the receiver's In. With STOP_BITS=1, back-to-back frames are accepted by the receiver without gaps.

---
 rtl/serial_transmitter.sv | 148 ++++++++++++++
 tb/tb_serial_transmitter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
// serial_transmitter: buffers parallel bytes in a small FIFO and sends each one
// on a single idle-high line at one bit per clock. Each frame is a 0 start bit,
// then 8 data bits MSB first, then STOP_BITS stop bits of 1.
module serial_transmitter #(
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Enable,
  input  logic [7:0]                 WrData,
  input  logic                       WrValid,
  output logic                       WrReady,
  output logic                       Out,
  output logic                       Busy,
  output logic                       Done,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [1:0]    LastStop  = 2'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitCnt_q;
  logic [1:0]    stopCnt_q;
  logic          out_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic          push;
  logic          pop;
  logic          lastStop;

  // Handshake and frame-start decisions, all taken from registered state.
  // A frame can start from IDLE or straight out of the final stop cycle.
  always_comb begin
    lastStop = (state_q == STOP) && (stopCnt_q == LastStop);
    WrReady  = (count_q < FullCount);
    push     = WrValid && WrReady;
    pop      = Enable && (count_q != '0) && ((state_q == IDLE) || lastStop);
  end

  // Occupancy next value; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= WrData;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Frame sequencer driving the registered serial line.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      out_q     <= 1'b1;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rdPtr_q];
            out_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          out_q    <= shift_q[7];
          bitCnt_q <= '0;
          state_q  <= DATA;
        end
        DATA: begin
          if (bitCnt_q == 3'd7) begin
            out_q     <= 1'b1;
            stopCnt_q <= '0;
            state_q   <= STOP;
          end else begin
            shift_q  <= {shift_q[6:0], 1'b0};
            out_q    <= shift_q[6];
            bitCnt_q <= bitCnt_q + 3'd1;
          end
        end
        STOP: begin
          if (lastStop) begin
            if (pop) begin
              shift_q <= mem_q[rdPtr_q];
              out_q   <= 1'b0;
              state_q <= START;
            end else begin
              out_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            out_q     <= 1'b1;
            stopCnt_q <= stopCnt_q + 2'd1;
          end
        end
        default: begin
          out_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Out   = out_q;
  assign Busy  = (state_q != IDLE);
  assign Done  = lastStop;
  assign Count = count_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: directed stimulus with a byte scoreboard. Accepted
// bytes are queued when written; a line decoder rebuilds frames from Out and
// compares each against the queue head.
module tb_serial_transmitter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clock   = 1'b0;
  logic          Reset   = 1'b1;
  logic          Enable  = 1'b0;
  logic [7:0]    WrData  = 8'h00;
  logic          WrValid = 1'b0;
  logic          WrReady;
  logic          Out;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;

  int            tests = 0;
  int            fails = 0;
  int            framesSeen = 0;
  logic [7:0]    expQ[$];

  serial_transmitter #(.DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .WrData  (WrData),
    .WrValid (WrValid),
    .WrReady (WrReady),
    .Out     (Out),
    .Busy    (Busy),
    .Done    (Done),
    .Count   (Count)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Drive one byte for one clock; queue it if the FIFO should accept it.
  task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
    WrValid = 1'b1;
    WrData  = data;
    if (expectAccept) expQ.push_back(data);
    tick();
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (!(Busy === 1'b0 && Count === '0) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("waitIdle", (Busy === 1'b0 && Count === '0), 1);
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    else if (i <= 8) return b[8-i];
    else return 1'b1;
  endfunction

  // Line decoder: rebuilds frames from Out and pops the scoreboard per frame.
  typedef enum {D_IDLE, D_DATA, D_STOP} dstate_t;
  dstate_t    dState = D_IDLE;
  int         dIdx   = 0;
  logic [7:0] dByte  = 8'h00;
  logic [7:0] dExp;

  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      dState <= D_IDLE;
    end else begin
      case (dState)
        D_IDLE: begin
          if (Out === 1'b0) begin
            checkOutput("startBusy", Busy, 1);
            dIdx   <= 0;
            dState <= D_DATA;
          end
        end
        D_DATA: begin
          dByte <= {dByte[6:0], Out};
          checkOutput("dataDoneLow", Done, 0);
          if (dIdx == 7) dState <= D_STOP;
          else dIdx <= dIdx + 1;
        end
        D_STOP: begin
          checkOutput("stopBit", Out, 1);
          checkOutput("stopDone", Done, 1);
          framesSeen <= framesSeen + 1;
          checkOutput("frameExpected", (expQ.size() != 0), 1);
          if (expQ.size() != 0) begin
            dExp = expQ.pop_front();
            checkOutput("frameByte", dByte, dExp);
          end
          dState <= D_IDLE;
        end
        default: dState <= D_IDLE;
      endcase
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    int n;

    // Reset
    Reset  = 1'b1;
    Enable = 1'b1;
    tick();
    tick();
    checkOutput("rstOut", Out, 1);
    checkOutput("rstBusy", Busy, 0);
    checkOutput("rstDone", Done, 0);
    checkOutput("rstCount", Count, 0);
    checkOutput("rstReady", WrReady, 1);
    Reset = 1'b0;
    tick();

    // Single byte 0xA5
    applyStimulus(8'hA5, 1'b1);
    WrValid = 1'b0;
    checkOutput("singleCount", Count, 1);
    checkOutput("singleIdleOut", Out, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput("singleOut", Out, frameBit(8'hA5, i));
      checkOutput("singleDone", Done, (i == 9));
      checkOutput("singleBusy", Busy, 1);
      tick();
    end
    checkOutput("singleBusyAfter", Busy, 0);
    checkOutput("singleDoneAfter", Done, 0);
    checkOutput("singleOutAfter", Out, 1);
    checkOutput("singleCountAfter", Count, 0);

    // Back-to-back 0x00 then 0xFF
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    WrValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("b2bOut", Out, frameBit((i < 10) ? 8'h00 : 8'hFF, i % 10));
      checkOutput("b2bDone", Done, ((i % 10) == 9));
      checkOutput("b2bBusy", Busy, 1);
      tick();
    end
    checkOutput("b2bBusyAfter", Busy, 0);

    // Full FIFO during an in-flight frame
    f0 = framesSeen;
    applyStimulus(8'hF0, 1'b1);
    WrValid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("fullReady", WrReady, (k < 4));
      applyStimulus(8'(8'h11 * (k + 1)), (k < 4));
    end
    WrValid = 1'b0;
    checkOutput("fullCount", Count, 4);
    checkOutput("fullReadyLow", WrReady, 0);
    n = 0;
    while (WrReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("fullReadyRestored", WrReady, 1);
    checkOutput("fullCountAfterPop", Count, 3);
    waitIdle(200);
    checkOutput("fullFrames", framesSeen - f0, 5);

    // Reset mid-frame at data bit 3 of 0x3C with two bytes queued
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    WrValid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midBit3", Out, 1);
    checkOutput("midCount", Count, 2);
    Reset = 1'b1;
    expQ.delete();
    tick();
    checkOutput("midRstOut", Out, 1);
    checkOutput("midRstBusy", Busy, 0);
    checkOutput("midRstCount", Count, 0);
    tick();
    Reset = 1'b0;
    f0 = framesSeen;
    repeat (30) tick();
    checkOutput("midNoFrames", framesSeen - f0, 0);
    checkOutput("midIdleOut", Out, 1);
    checkOutput("midIdleBusy", Busy, 0);

    // Enable hold
    Enable = 1'b0;
    applyStimulus(8'h81, 1'b1);
    WrValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("holdOut", Out, 1);
      checkOutput("holdCount", Count, 1);
      checkOutput("holdBusy", Busy, 0);
      tick();
    end
    Enable = 1'b1;
    tick();
    checkOutput("enStartOut", Out, 0);
    checkOutput("enStartBusy", Busy, 1);
    tick();
    tick();
    Enable = 1'b0;
    for (int i = 2; i < 10; i++) begin
      checkOutput("enDropOut", Out, frameBit(8'h81, i));
      checkOutput("enDropBusy", Busy, 1);
      tick();
    end
    checkOutput("enDoneBusy", Busy, 0);
    checkOutput("enDoneOut", Out, 1);
    checkOutput("enDoneCount", Count, 0);
    Enable = 1'b1;
    tick();

    // Loopback burst decoded by the line decoder
    f0 = framesSeen;
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'h01, 1'b1);
    WrValid = 1'b0;
    waitIdle(100);
    checkOutput("loopFrames", framesSeen - f0, 3);
    checkOutput("loopQueueEmpty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
